// File: rtl/varint_pkg.sv
// Shared types and helpers for the LEB128 varint stream encoder.
// Provides the FSM state enum, the per-width byte budget, zigzag mapping
// and the encoded length of a (zigzag-mapped) value.
package varint_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned LEN_W      = 4;   // holds byte counts up to 10

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Worst-case encoded length for a data_w-bit field.
  function automatic int unsigned max_bytes(input int unsigned data_w);
    return (data_w + 6) / 7;
  endfunction

  // Zigzag map on a 64-bit value. Narrower signed fields must be
  // sign-extended by the caller; the result then equals the narrow zigzag
  // value zero-extended, so one function covers every width.
  function automatic logic [MAX_DATA_W-1:0] zigzag(input logic [MAX_DATA_W-1:0] value,
                                                    input logic                  signed_en);
    if (signed_en) return (value << 1) ^ {MAX_DATA_W{value[MAX_DATA_W-1]}};
    return value;
  endfunction

  // Number of 7-bit groups needed for z; zero still takes one byte.
  function automatic logic [LEN_W-1:0] varint_len(input logic [MAX_DATA_W-1:0] z);
    int unsigned bits;
    bits = 0;
    for (int i = 0; i < int'(MAX_DATA_W); i++) begin
      if (z[i]) bits = i + 1;
    end
    if (bits == 0) return LEN_W'(1);
    return LEN_W'((bits + 6) / 7);
  endfunction

endpackage

// File: rtl/varint_stream_encoder_if.sv
// Word-in / byte-beat-out stream bundle for the varint encoder.
//   in_*  : one raw field per valid/ready handshake, with signed flag and tag
//   out_* : LANES encoded bytes per beat with keep mask, last flag and tag
// slave  = encoder side, master = producer/consumer side.
interface varint_stream_encoder_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANES  = 4,
  parameter int unsigned IDX_W  = 10
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 in_signed;
  logic [IDX_W-1:0]     in_index;

  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [LANES-1:0]     out_keep;
  logic                 out_last;
  logic [IDX_W-1:0]     out_index;

  modport slave (
    input  in_valid, in_data, in_signed, in_index, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, out_index
  );

  modport master (
    output in_valid, in_data, in_signed, in_index, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, out_index
  );

endinterface

// File: rtl/varint_byte_pack.sv
// Combinational LEB128 packer: splits a zigzag-mapped value into 7-bit
// groups, sets the continuation bit on all but the final byte, and reports
// the number of significant bytes.
//   z     : mapped value
//   bytes : MAX_BYTES encoded bytes, byte 0 = least significant group
//   n     : encoded length, 1..MAX_BYTES
module varint_byte_pack
  import varint_pkg::*;
#(
  parameter  int unsigned DATA_W    = 64,
  localparam int unsigned MAX_BYTES = max_bytes(DATA_W)
) (
  input  logic [DATA_W-1:0]          z,
  output logic [MAX_BYTES-1:0][7:0]  bytes,
  output logic [LEN_W-1:0]           n
);

  localparam int unsigned PAD_W = 7 * MAX_BYTES;

  logic [PAD_W-1:0] z_pad;

  assign z_pad = PAD_W'(z);
  assign n     = varint_len(MAX_DATA_W'(z));

  // Continuation bit is set on every byte below the last one.
  always_comb begin
    bytes = '0;
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      bytes[k] = {(LEN_W'(k + 1) < n), z_pad[7*k +: 7]};
    end
  end

endmodule

// File: rtl/varint_stream_encoder.sv
// Streaming LEB128 varint encoder.
// Accepts one DATA_W-bit word per input handshake, optionally zigzag maps
// it, and emits the encoded bytes LANES at a time with keep/last/index.
//   clock_clk, reset_reset_n : clock, async active-low reset
//   clr                      : synchronous flush of the in-flight word
//   s                        : stream bundle (slave side)
//   busy                     : a word is being emitted
//   word_cnt                 : words fully emitted, wrapping
module varint_stream_encoder
  import varint_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANES  = 4,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clock_clk,
  input  logic                       reset_reset_n,
  input  logic                       clr,
  varint_stream_encoder_if.slave     s,
  output logic                       busy,
  output logic [CNT_W-1:0]           word_cnt
);

  localparam int unsigned MAX_BYTES = max_bytes(DATA_W);
  localparam int unsigned PTR_W     = $clog2(MAX_BYTES + LANES + 1);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("varint_stream_encoder: DATA_W must be 32 or 64");
  end
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("varint_stream_encoder: LANES must be 1, 2, 4 or 8");
  end

  state_t                      state;
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            n_q;
  logic [MAX_BYTES-1:0][7:0]   bytes_q;

  logic [MAX_DATA_W-1:0]       in_ext;
  logic [DATA_W-1:0]           z;
  logic [MAX_BYTES-1:0][7:0]   pack_bytes;
  logic [LEN_W-1:0]            pack_n;

  logic                        in_hs;
  logic                        out_hs;

  logic [PTR_W-1:0]            nxt_ptr;
  logic [PTR_W-1:0]            src_n;
  logic [MAX_BYTES-1:0][7:0]   src_bytes;
  logic [8*LANES-1:0]          nxt_data;
  logic [LANES-1:0]            nxt_keep;
  logic                        nxt_last;

  // Sign-extend signed fields so the 64-bit zigzag is correct at any width.
  assign in_ext = s.in_signed ? MAX_DATA_W'($signed(s.in_data)) : MAX_DATA_W'(s.in_data);
  assign z      = DATA_W'(zigzag(in_ext, s.in_signed));

  varint_byte_pack #(.DATA_W(DATA_W)) u_pack (
    .z     (z),
    .bytes (pack_bytes),
    .n     (pack_n)
  );

  // Ready also opens on the final beat's handshake for zero-bubble reloads.
  assign s.in_ready = reset_reset_n && !clr &&
                      (state == IDLE || (s.out_valid && s.out_ready && s.out_last));
  assign in_hs      = s.in_valid && s.in_ready;
  assign out_hs     = s.out_valid && s.out_ready;

  // Next beat: first beat of a freshly accepted word, or the following
  // LANES bytes of the held word.
  always_comb begin
    nxt_ptr   = in_hs ? '0 : ptr + PTR_W'(LANES);
    src_bytes = in_hs ? pack_bytes : bytes_q;
    src_n     = in_hs ? PTR_W'(pack_n) : n_q;
    nxt_data  = '0;
    nxt_keep  = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      nxt_keep[j] = (nxt_ptr + PTR_W'(j)) < src_n;
      for (int k = 0; k < int'(MAX_BYTES); k++) begin
        if (nxt_keep[j] && (nxt_ptr + PTR_W'(j)) == PTR_W'(k)) begin
          nxt_data[8*j +: 8] = src_bytes[k];
        end
      end
    end
    nxt_last = (nxt_ptr + PTR_W'(LANES)) >= src_n;
  end

  // FSM, beat registers and completed-word counter.
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      n_q         <= '0;
      bytes_q     <= '0;
      busy        <= 1'b0;
      word_cnt    <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_keep  <= '0;
      s.out_last  <= 1'b0;
      s.out_index <= '0;
    end else if (clr) begin
      state       <= IDLE;
      ptr         <= '0;
      busy        <= 1'b0;
      s.out_valid <= 1'b0;
    end else begin
      if (out_hs && s.out_last) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (in_hs) begin
        state       <= EMIT;
        busy        <= 1'b1;
        bytes_q     <= pack_bytes;
        n_q         <= PTR_W'(pack_n);
        ptr         <= nxt_ptr;
        s.out_valid <= 1'b1;
        s.out_data  <= nxt_data;
        s.out_keep  <= nxt_keep;
        s.out_last  <= nxt_last;
        s.out_index <= s.in_index;
      end else if (out_hs) begin
        if (s.out_last) begin
          state       <= IDLE;
          busy        <= 1'b0;
          s.out_valid <= 1'b0;
        end else begin
          ptr         <= nxt_ptr;
          s.out_data  <= nxt_data;
          s.out_keep  <= nxt_keep;
          s.out_last  <= nxt_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_varint_stream_encoder.sv
// Self-checking bench for varint_stream_encoder.
// A 64-bit / 4-lane instance is tracked every cycle against a byte-queue
// LEB128 model; a 32-bit / 1-lane instance runs directed words with a stall.
module tb_varint_stream_encoder;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr64;
  logic        clr32;
  logic        busy64, busy32;
  logic [15:0] cnt64, cnt32;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random

  always #5 clk = ~clk;

  varint_stream_encoder_if #(.DATA_W(64), .LANES(4), .IDX_W(10)) bus64 ();
  varint_stream_encoder_if #(.DATA_W(32), .LANES(1), .IDX_W(10)) bus32 ();

  varint_stream_encoder #(.DATA_W(64), .LANES(4), .IDX_W(10), .CNT_W(16)) dut64 (
    .clock_clk(clk), .reset_reset_n(rst_n), .clr(clr64), .s(bus64),
    .busy(busy64), .word_cnt(cnt64)
  );

  varint_stream_encoder #(.DATA_W(32), .LANES(1), .IDX_W(10), .CNT_W(16)) dut32 (
    .clock_clk(clk), .reset_reset_n(rst_n), .clr(clr32), .s(bus32),
    .busy(busy32), .word_cnt(cnt32)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference LEB128: zigzag by signed arithmetic, then base-128 digits.
  function automatic bq_t leb128(input logic [63:0] d, input int unsigned w, input logic sg);
    bq_t         q;
    logic [63:0] zv;
    longint      sv;
    logic [7:0]  b;
    if (w == 32) sv = longint'($signed(d[31:0]));
    else         sv = longint'($signed(d));
    if (!sg)          zv = (w == 32) ? {32'h0, d[31:0]} : d;
    else if (sv >= 0) zv = 64'(sv) * 64'd2;
    else              zv = 64'(-sv) * 64'd2 - 64'd1;
    do begin
      b  = 8'(zv % 64'd128);
      zv = zv / 64'd128;
      if (zv != 0) b = b | 8'h80;
      q.push_back(b);
    end while (zv != 0);
    return q;
  endfunction

  // out_ready driver for the 64-bit instance.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus64.out_ready = 1'b0;
      1:       bus64.out_ready = 1'b1;
      default: bus64.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Cycle-by-cycle model of the 64-bit instance.
  bq_t         cur_q;
  logic        cur_active = 1'b0;
  logic [9:0]  cur_idx    = '0;
  logic [15:0] exp_cnt    = '0;
  logic        exp_rdy;
  logic        exp_last;
  logic [31:0] exp_data;
  logic [3:0]  exp_keep;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_out_valid", 64'(bus64.out_valid), 64'd0);
      check_eq("rst_out_data",  64'(bus64.out_data),  64'd0);
      check_eq("rst_out_keep",  64'(bus64.out_keep),  64'd0);
      check_eq("rst_out_last",  64'(bus64.out_last),  64'd0);
      check_eq("rst_out_index", 64'(bus64.out_index), 64'd0);
      check_eq("rst_busy",      64'(busy64),          64'd0);
      check_eq("rst_word_cnt",  64'(cnt64),           64'd0);
      check_eq("rst_in_ready",  64'(bus64.in_ready),  64'd0);
      cur_active = 1'b0;
      cur_q.delete();
      exp_cnt = '0;
    end else begin
      exp_last = cur_active && (cur_q.size() <= 4);
      exp_rdy  = !clr64 && (!cur_active || (bus64.out_ready && exp_last));
      check_eq("word_cnt",  64'(cnt64),           64'(exp_cnt));
      check_eq("busy",      64'(busy64),          64'(cur_active));
      check_eq("out_valid", 64'(bus64.out_valid), 64'(cur_active));
      check_eq("in_ready",  64'(bus64.in_ready),  64'(exp_rdy));
      if (clr64) begin
        cur_active = 1'b0;
        cur_q.delete();
      end else begin
        if (cur_active && bus64.out_valid) begin
          exp_data = '0;
          exp_keep = '0;
          for (int j = 0; j < 4; j++) begin
            if (j < cur_q.size()) begin
              exp_data[8*j +: 8] = cur_q[j];
              exp_keep[j]        = 1'b1;
            end
          end
          check_eq("out_data",  64'(bus64.out_data),  64'(exp_data));
          check_eq("out_keep",  64'(bus64.out_keep),  64'(exp_keep));
          check_eq("out_last",  64'(bus64.out_last),  64'(exp_last));
          check_eq("out_index", 64'(bus64.out_index), 64'(cur_idx));
          if (bus64.out_ready) begin
            for (int j = 0; j < 4; j++) begin
              if (cur_q.size() > 0) void'(cur_q.pop_front());
            end
            if (exp_last) begin
              cur_active = 1'b0;
              exp_cnt    = exp_cnt + 16'd1;
            end
          end
        end
        if (bus64.in_valid && bus64.in_ready) begin
          cur_q      = leb128(bus64.in_data, 64, bus64.in_signed);
          cur_idx    = bus64.in_index;
          cur_active = 1'b1;
        end
      end
    end
  end

  // Offer one word; returns at posedge+1 after it is accepted.
  task automatic send64(input logic [63:0] d, input logic sg, input logic [9:0] idx,
                        input bit hold);
    int t;
    bus64.in_valid  = 1'b1;
    bus64.in_data   = d;
    bus64.in_signed = sg;
    bus64.in_index  = idx;
    t = 0;
    @(negedge clk);
    while (!(bus64.in_valid && bus64.in_ready) && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check_eq("in_hs_timeout", 64'(bus64.in_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) bus64.in_valid = 1'b0;
  endtask

  task automatic wait_idle64();
    int t;
    t = 0;
    @(negedge clk);
    while (busy64 && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check_eq("drain_timeout", 64'(busy64), 64'd0);
    @(posedge clk);
    #1;
  endtask

  int exp_cnt32 = 0;

  // One word through the 1-lane instance, optionally stalling at one beat.
  task automatic run32(input logic [31:0] v, input logic sg, input logic [9:0] idx,
                       input int stall_beat);
    bq_t q;
    int  t;
    q = leb128(64'(v), 32, sg);
    bus32.in_valid  = 1'b1;
    bus32.in_data   = v;
    bus32.in_signed = sg;
    bus32.in_index  = idx;
    bus32.out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(bus32.in_valid && bus32.in_ready) && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) check_eq("in32_hs_timeout", 64'(bus32.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    for (int b = 0; b < q.size(); b++) begin
      t = 0;
      @(negedge clk);
      while (!bus32.out_valid && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (b == stall_beat) begin
        bus32.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_eq("stall_valid",    64'(bus32.out_valid), 64'd1);
          check_eq("stall_data",     64'(bus32.out_data),  64'(q[b]));
          check_eq("stall_in_ready", 64'(bus32.in_ready),  64'd0);
        end
        bus32.out_ready = 1'b1;
      end
      check_eq("b32_valid", 64'(bus32.out_valid), 64'd1);
      check_eq("b32_data",  64'(bus32.out_data),  64'(q[b]));
      check_eq("b32_keep",  64'(bus32.out_keep),  64'd1);
      check_eq("b32_last",  64'(bus32.out_last),  64'(b == q.size() - 1));
      check_eq("b32_index", 64'(bus32.out_index), 64'(idx));
    end
    exp_cnt32++;
    @(negedge clk);
    check_eq("b32_idle_valid", 64'(bus32.out_valid), 64'd0);
    check_eq("b32_word_cnt",   64'(cnt32),           64'(exp_cnt32));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    clr64           = 1'b0;
    clr32           = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.in_data   = '0;
    bus64.in_signed = 1'b0;
    bus64.in_index  = '0;
    bus32.in_valid  = 1'b0;
    bus32.in_data   = '0;
    bus32.in_signed = 1'b0;
    bus32.in_index  = '0;
    bus32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed words on the 64-bit instance.
    send64(64'd0, 1'b0, 10'h000, 1'b0);
    send64(64'd300, 1'b0, 10'h155, 1'b0);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 10'h001, 1'b0);
    send64(64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 10'h002, 1'b0);
    send64(64'd64, 1'b1, 10'h003, 1'b0);
    send64(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 10'h004, 1'b0);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'h005, 1'b0);
    wait_idle64();

    // Back-to-back single-beat words must stream with no gap.
    fork
      begin
        send64(64'd1, 1'b0, 10'h011, 1'b1);
        send64(64'd2, 1'b0, 10'h012, 1'b1);
        send64(64'd3, 1'b0, 10'h013, 1'b0);
      end
      begin : b2b_watch
        int t;
        t = 0;
        @(negedge clk);
        while (!bus64.out_valid && t < 20) begin
          t++;
          @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
          check_eq("b2b_valid", 64'(bus64.out_valid),     64'd1);
          check_eq("b2b_byte",  64'(bus64.out_data[7:0]), 64'(k + 1));
          @(negedge clk);
        end
      end
    join
    wait_idle64();

    // Random words with random gaps and backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom} >> $urandom_range(0, 63);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send64(d, 1'($urandom_range(0, 1)), 10'($urandom), 1'b0);
    end
    rdy_mode = 1;
    wait_idle64();

    // Flush at the second beat of a three-beat word.
    send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'h03A, 1'b0);
    @(posedge clk);
    #1;
    clr64 = 1'b1;
    @(posedge clk);
    #1;
    clr64 = 1'b0;
    @(negedge clk);
    check_eq("clr_out_valid", 64'(bus64.out_valid), 64'd0);
    @(posedge clk);
    #1;
    send64(64'd5, 1'b0, 10'h03B, 1'b0);
    wait_idle64();

    // Asynchronous reset while a word is stalled mid-emission.
    rdy_mode = 0;
    send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'h0C4, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("arst_out_valid", 64'(bus64.out_valid), 64'd0);
    check_eq("arst_word_cnt",  64'(cnt64),           64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 1;
    send64(64'd7, 1'b0, 10'h0C5, 1'b0);
    wait_idle64();

    // 32-bit, single-lane instance.
    run32(32'hFFFF_FFFF, 1'b0, 10'h021, 2);
    run32(32'hFFFF_FFFF, 1'b1, 10'h022, -1);
    run32(32'h7FFF_FFFF, 1'b1, 10'h023, -1);
    run32(32'h8000_0000, 1'b1, 10'h024, -1);
    run32(32'd300, 1'b0, 10'h025, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/varint_stream_encoder.md
Name: varint_stream_encoder

Overview:
- Parametrised streaming LEB128 varint encoder. Successor to the single-width, byte-serial varint path behind the AXI4 slave.
- Accepts one DATA_W-bit word per handshake, optionally zigzag-maps it for signed fields, and emits the encoded bytes LANES at a time on a valid/ready byte stream.
- Each output beat carries a keep mask, a last flag and the word's index tag, which the downstream merge stage uses to re-order against raw data.

Parameters:
- DATA_W, 64, input word width; legal values 32 or 64.
- LANES, 4, output bytes per beat; legal values 1, 2, 4, 8.
- IDX_W, 10, width of the index tag carried with each word.
- CNT_W, 16, width of the encoded-word counter.

Ports:
- clock_clk  in  1  sole clock; all logic is rising-edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid and in_ready are both high.
- in_data  in  DATA_W  raw field value.
- in_signed  in  1  1 = zigzag-encode (sint32/sint64); 0 = plain unsigned.
- in_index  in  IDX_W  tag, returned on every beat of that word.
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat accepted.
- out_data  out  8*LANES  encoded bytes, lane 0 = bits [7:0] = earliest byte.
- out_keep  out  LANES  valid-lane mask, contiguous from lane 0.
- out_last  out  1  final beat of the current word.
- out_index  out  IDX_W  tag of the word being emitted.
- busy  out  1  high in EMIT state.
- word_cnt  out  CNT_W  count of words fully emitted; wraps.

Behaviour:
- Constants: MAX_BYTES = (DATA_W+6)/7, giving 5 for 32 and 10 for 64.
- Zigzag (in_signed=1): z = (d<<1) ^ {DATA_W{d[DATA_W-1]}}. Otherwise z = d.
- Byte count N = max(1, ceil(msb_pos(z)+1 / 7)).
- Byte k (k<N) = {k<N-1, z[7k+6:7k]}. Bits of z above 7·MAX_BYTES are zero-padded.

FSM:
- States: IDLE and EMIT.
- IDLE -> EMIT on input handshake. Latch the N-byte vector, N, in_index, and set ptr=0.
- EMIT, each beat:
  - out_data lane j = byte[ptr+j] if ptr+j<N, else 8'h00.
  - out_keep[j] = (ptr+j<N).
  - out_last = (ptr+LANES>=N).
- On out_valid&&out_ready: if !out_last, ptr += LANES and stay in EMIT.
- If out_last: go to IDLE, or reload directly if a new input handshake occurs in the same cycle.
- in_ready = reset_reset_n && !clr && (state==IDLE || (out_valid && out_ready && out_last)).
  - This is a combinational path from out_ready to in_ready; it is intended.
  - It gives zero-bubble back-to-back words.

Timing and handshake:
- Latency: a word accepted at edge t presents its first beat with out_valid=1 after edge t. Beats per word = ceil(N/LANES).
- out_valid, out_data, out_keep, out_last and out_index are registered. They are held stable while out_valid && !out_ready.
- out_valid never drops without a handshake except on clr or reset.
- word_cnt increments on each handshake with out_last=1. It wraps at 2^CNT_W.

Flush and reset:
- clr (sync): next cycle state=IDLE, out_valid=0 and in_ready=0 while clr is high. The in-flight word is discarded and not counted. word_cnt is NOT cleared.
- Reset (async, any time including mid-word) forces:
  - state=IDLE, ptr=0
  - out_valid=0, out_data=0, out_keep=0, out_last=0, out_index=0
  - busy=0, word_cnt=0
- in_ready=0 while reset_reset_n is low.
- in_valid while !in_ready: the word is held by upstream, never dropped.

Decomposition:
- Package varint_pkg holds:
  - the state enum {IDLE, EMIT}
  - function max_bytes(DATA_W)
  - function zigzag(value, signed_en)
  - function varint_len(z)
- Sub-module varint_byte_pack is purely combinational: takes z, returns the byte vector [MAX_BYTES][8] and N. The top holds the FSM, ptr, output registers and counter.
- Elaboration check: fail on illegal DATA_W or LANES.

Test Plan:
- DATA_W=64, LANES=4, unsigned 0 -> one beat, out_data[7:0]=8'h00, keep=4'b0001, last=1, word_cnt=1.
- Unsigned 300 with index 10'h155 -> one beat with bytes AC 02, keep=4'b0011, last=1, out_index=10'h155.
- Signed values, zigzag: -1 -> 8'h01; -64 -> 8'h7F; 64 -> bytes 80 01 (keep 0011); 0x7FFF_FFFF_FFFF_FFFF -> FE FF×8 01, 10 bytes.
- Unsigned 64'hFFFF_FFFF_FFFF_FFFF -> 3 beats:
  - FF FF FF FF, keep 1111
  - FF FF FF FF, keep 1111
  - FF 01, keep 0011, last=1
- DATA_W=32, LANES=1: unsigned 32'hFFFFFFFF -> 5 beats FF FF FF FF 0F. Hold out_ready low 5 cycles at beat 3: outputs stay stable, in_ready stays 0.
- Back-to-back words 1, 2, 3 with in_valid and out_ready held high -> one beat per cycle with no bubble. Then assert clr at beat 2 of a 3-beat word, and separately assert reset_reset_n low mid-word: out_valid=0 the next cycle, the dropped word is not counted, reset zeroes word_cnt.
